// File: rtl/memory_playback_sequencer.sv
// memory_playback_sequencer: rewinds the song memory, fetches one note word per step over the
// read_en/ready handshake, and holds each note for its encoded length before a silent gap.
// LEARNING mode holds a sounding note until the player presses the matching key.
// Build option: define SEQ_LOOP_EN to make AUTOPLAY restart from the top after each song.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start; done pulse for an empty song, abort rewind
// S_REWIND | one-cycle read-pointer rewind, note_index cleared
// S_FETCH  | one-cycle fetch strobe to memory
// S_WAIT   | waiting for memory ready, bounded by WAIT_TIMEOUT
// S_PLAY   | note sounding for max(len,1) beat units
// S_HOLD   | LEARNING: note held until key_note matches
// S_GAP    | silence between notes, then next note or finish
// S_DONE   | one-cycle done pulse
module memory_playback_sequencer #(
  parameter int DATA_WIDTH    = 8,
  parameter int LEN_W         = 3,
  parameter int MAX_DEPTH_BIT = 8,
  parameter int TICK_DIV      = 2500000,
  parameter int GAP_CYCLES    = 250000,
  parameter int WAIT_TIMEOUT  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  current_state,
  input  logic                        start,
  input  logic                        stop,
  input  logic [DATA_WIDTH-LEN_W-1:0] key_note,
  input  logic [DATA_WIDTH-1:0]       mem_data,
  input  logic                        mem_ready,
  input  logic [MAX_DEPTH_BIT-1:0]    duration,
  output logic                        mem_read_en,
  output logic                        mem_read_rst,
  output logic [DATA_WIDTH-LEN_W-1:0] note_out,
  output logic                        note_valid,
  output logic [MAX_DEPTH_BIT-1:0]    note_index,
  output logic                        hint_wait,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam int CODE_W   = DATA_WIDTH - LEN_W;
  localparam int BEAT_MAX = ((2 ** LEN_W) - 1) * TICK_DIV;
  // one shared down-counter covers beat, gap and wait timing
  localparam int CNT_W    = $clog2(BEAT_MAX + GAP_CYCLES + WAIT_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] TICK_L = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] GAP_L  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_L = CNT_W'(WAIT_TIMEOUT - 1);

  localparam logic [1:0] MODE_AUTO  = 2'b00;
  localparam logic [1:0] MODE_LEARN = 2'b01;
  localparam logic [1:0] MODE_OTHER = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_FETCH, S_WAIT, S_PLAY, S_HOLD, S_GAP, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MAX_DEPTH_BIT-1:0] idx_q, idx_d;
  logic [CODE_W-1:0]        code_q, code_d;
  logic [1:0]               mode_q, mode_d;
  logic                     err_q, err_d;
  logic                     abort_q, abort_d;
  logic                     zdone_q, zdone_d;
  logic [LEN_W-1:0]         len_eff;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // datapath registers: timer, note index, latched note/mode, status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      code_q  <= '0;
      mode_q  <= '0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      zdone_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      zdone_q <= zdone_d;
    end
  end

  // next-state, timer loads and Moore outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    code_d  = code_q;
    mode_d  = mode_q;
    err_d   = err_q;
    abort_d = 1'b0;
    zdone_d = 1'b0;
    len_eff = (mem_data[LEN_W-1:0] == '0) ? LEN_W'(1) : mem_data[LEN_W-1:0];

    // stop or a mode change outranks everything else while busy
    if (state_q != S_IDLE && (stop || current_state != mode_q)) begin
      state_d = S_IDLE;
      abort_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && current_state != MODE_OTHER) begin
            mode_d = current_state;
            err_d  = 1'b0;
            if (duration == '0) zdone_d = 1'b1;
            else                state_d = S_REWIND;
          end
        end
        S_REWIND: begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
        S_FETCH: begin
          cnt_d   = WAIT_L;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          if (mem_ready) begin
            code_d  = mem_data[DATA_WIDTH-1:LEN_W];
            cnt_d   = CNT_W'(len_eff) * TICK_L - CNT_W'(1);
            state_d = S_PLAY;
          end else if (cnt_q == '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_PLAY: begin
          if (cnt_q == '0) begin
            if (mode_q == MODE_LEARN && code_q != '0 && key_note != code_q) begin
              state_d = S_HOLD;
            end else begin
              cnt_d   = GAP_L;
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (key_note == code_q) begin
            cnt_d   = GAP_L;
            state_d = S_GAP;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            if (idx_q == duration - MAX_DEPTH_BIT'(1)) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + MAX_DEPTH_BIT'(1);
              state_d = S_FETCH;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
`ifdef SEQ_LOOP_EN
          state_d = (mode_q == MODE_AUTO) ? S_REWIND : S_IDLE;
`else
          state_d = S_IDLE;
`endif
        end
        default: state_d = S_IDLE;
      endcase
    end

    mem_read_en  = (state_q == S_FETCH);
    mem_read_rst = (state_q == S_REWIND) || abort_q;
    note_valid   = (state_q == S_PLAY) || (state_q == S_HOLD);
    note_out     = note_valid ? code_q : '0;
    hint_wait    = (state_q == S_HOLD);
    busy         = (state_q != S_IDLE);
    done         = (state_q == S_DONE) || zdone_q;
  end

  assign note_index = idx_q;
  assign err        = err_q;

endmodule

// File: tb/tb_memory_playback_sequencer.sv
// Directed bench for memory_playback_sequencer with short timing parameters
// (TICK_DIV=4, GAP_CYCLES=2, WAIT_TIMEOUT=16) and a memory that answers one cycle after read_en.
module tb_memory_playback_sequencer;

  localparam int DW = 8;
  localparam int LW = 3;
  localparam int MB = 8;
  localparam int CW = DW - LW;
`ifdef SEQ_LOOP_EN
  localparam int LOOP = 1;
`else
  localparam int LOOP = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    current_state = 2'b00;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] key_note = '0;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic [MB-1:0] duration = '0;
  logic          mem_read_en, mem_read_rst, note_valid, hint_wait, busy, done, err;
  logic [CW-1:0] note_out;
  logic [MB-1:0] note_index;

  always #5 clk = ~clk;

  memory_playback_sequencer #(
    .DATA_WIDTH(DW), .LEN_W(LW), .MAX_DEPTH_BIT(MB),
    .TICK_DIV(4), .GAP_CYCLES(2), .WAIT_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .current_state(current_state), .start(start), .stop(stop),
    .key_note(key_note), .mem_data(mem_data), .mem_ready(mem_ready), .duration(duration),
    .mem_read_en(mem_read_en), .mem_read_rst(mem_read_rst), .note_out(note_out),
    .note_valid(note_valid), .note_index(note_index), .hint_wait(hint_wait),
    .busy(busy), .done(done), .err(err)
  );

  // song memory: rewinds on read_rst, answers a fetch with data and ready one cycle later
  logic [DW-1:0] mem [0:3];
  int            ptr;
  logic          mem_alive = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_data  <= '0;
      ptr       <= 0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_read_rst) ptr <= 0;
      else if (mem_read_en && mem_alive) begin
        mem_data  <= mem[ptr];
        ptr       <= ptr + 1;
        mem_ready <= 1'b1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  int n_rst, n_en, n_done, n_hint, n_ovl, first_valid, done_cyc, err_cyc, last_busy, last_en;
  int vcnt [32];

  task automatic go(input logic [1:0] mode, input logic [MB-1:0] dur);
    @(negedge clk);
    current_state = mode;
    duration      = dur;
    start         = 1'b1;
  endtask

  // observe ncyc cycles at the falling edge; cycle 1 is the first one after start was sampled
  task automatic window(input int ncyc);
    n_rst = 0; n_en = 0; n_done = 0; n_hint = 0; n_ovl = 0;
    first_valid = 0; done_cyc = 0; err_cyc = 0; last_busy = 0; last_en = 0;
    foreach (vcnt[i]) vcnt[i] = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (mem_read_rst) n_rst++;
      if (mem_read_en) begin n_en++; last_en = c; end
      if (mem_read_rst && mem_read_en) n_ovl++;
      if (done) begin n_done++; if (done_cyc == 0) done_cyc = c; end
      if (hint_wait) n_hint++;
      if (note_valid) begin vcnt[note_out]++; if (first_valid == 0) first_valid = c; end
      if (err && err_cyc == 0) err_cyc = c;
      if (busy) last_busy = c;
    end
  endtask

  task automatic settle();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    mem[0] = '0; mem[1] = '0; mem[2] = '0; mem[3] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", note_valid, 0);
    check("rst_read_rst", mem_read_rst, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_index", note_index, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // AUTOPLAY: {5,len2} then {3,len0}
    mem[0] = 8'h2A; mem[1] = 8'h18;
    go(2'b00, 8'd2);
    window(22);
    check("t1_first_valid", first_valid, 4);
    check("t1_note5_cycles", vcnt[5], 8);
    check("t1_note3_cycles", vcnt[3], 4);
    check("t1_read_rst", n_rst, 1);
    check("t1_read_en", n_en, 2);
    check("t1_second_fetch", last_en, 14);
    check("t1_done_cycle", done_cyc, 22);
    check("t1_done_count", n_done, 1);
    check("t1_overlap", n_ovl, 0);
    check("t1_index", note_index, 1);
    @(negedge clk);
    check("t1_busy_after", busy, LOOP);
    settle();

    // LEARNING: {7,len1} held until key 7
    mem[0] = 8'h39;
    key_note = '0;
    go(2'b01, 8'd1);
    window(10);
    check("t2_first_valid", first_valid, 4);
    check("t2_hint_cycles", n_hint, 3);
    check("t2_note7_cycles", vcnt[7], 7);
    check("t2_no_done", n_done, 0);
    key_note = 5'd7;
    window(4);
    check("t2_hint_after_key", n_hint, 0);
    check("t2_valid_after_key", vcnt[7], 0);
    check("t2_done_cycle", done_cyc, 3);
    key_note = '0;
    settle();

    // LEARNING rest then note: rest advances without HOLD, then stop during second note
    mem[0] = 8'h01; mem[1] = 8'h39;
    go(2'b01, 8'd2);
    window(13);
    check("t3_rest_cycles", vcnt[0], 4);
    check("t3_rest_hint", n_hint, 0);
    check("t3_second_fetch", last_en, 10);
    check("t3_playing", note_valid, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t4_stop_valid", note_valid, 0);
    check("t4_stop_read_rst", mem_read_rst, 1);
    check("t4_stop_busy", busy, 0);
    check("t4_stop_hint", hint_wait, 0);
    window(6);
    check("t4_stop_rst_once", n_rst, 0);
    check("t4_stop_no_done", n_done, 0);

    // AUTOPLAY aborted by a mode change 00 -> 11
    mem[0] = 8'h2A; mem[1] = 8'h18;
    go(2'b00, 8'd2);
    window(6);
    check("t4_mode_playing", note_valid, 1);
    current_state = 2'b11;
    @(negedge clk);
    check("t4_mode_valid", note_valid, 0);
    check("t4_mode_read_rst", mem_read_rst, 1);
    check("t4_mode_busy", busy, 0);
    window(8);
    check("t4_mode_rst_once", n_rst, 0);
    check("t4_mode_no_done", n_done, 0);
    check("t4_mode_no_fetch", n_en, 0);

    // start in mode 11 is ignored
    go(2'b11, 8'd2);
    window(4);
    check("t4_m11_busy", last_busy, 0);
    check("t4_m11_rst", n_rst, 0);
    current_state = 2'b00;
    repeat (2) @(negedge clk);

    // memory never ready: timeout after 16 WAIT cycles
    mem_alive = 1'b0;
    go(2'b00, 8'd1);
    window(20);
    check("t5_last_busy", last_busy, 18);
    check("t5_err_cycle", err_cyc, 19);
    check("t5_no_valid", first_valid, 0);
    check("t5_err_sticky", err, 1);
    mem_alive = 1'b1;
    // empty song: done next cycle, no fetch, err cleared
    go(2'b00, 8'd0);
    window(3);
    check("t5_zero_done_cycle", done_cyc, 1);
    check("t5_zero_done_count", n_done, 1);
    check("t5_zero_no_fetch", n_en, 0);
    check("t5_zero_no_rst", n_rst, 0);
    check("t5_zero_busy", last_busy, 0);
    check("t5_err_cleared", err, 0);

    // GAME ignores key_note
    mem[0] = 8'h29;
    go(2'b10, 8'd1);
    window(11);
    check("g_first_valid", first_valid, 4);
    check("g_note_cycles", vcnt[5], 4);
    check("g_hint", n_hint, 0);
    check("g_done_cycle", done_cyc, 10);
    settle();

`ifdef SEQ_LOOP_EN
    // AUTOPLAY loops until stopped
    mem[0] = 8'h29;
    go(2'b00, 8'd1);
    window(40);
    check("loop_done_count", n_done, 4);
    check("loop_rst_count", n_rst, 4);
    check("loop_busy", busy, 1);
    settle();
    check("loop_stopped", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
